// File: rtl/mem_arb_pkg.sv
// Shared types and lane helpers for the memory port arbiter and its lane aligner.
package mem_arb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    FETCH  = 2'd1,
    LS     = 2'd2,
    LS_MIS = 2'd3
  } owner_e;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      BYTE:    be = 4'b0001 << addr_lo;
      HALF:    be = 4'b0011 << addr_lo;
      WORD:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] addr_lo, input logic is_unsigned);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {addr_lo, 3'b000};
    case (size)
      BYTE:    res = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
      HALF:    res = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
      WORD:    res = rdata;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte enables and replication, load lane select and extension.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rsp_size,
  input  logic [1:0]  i_rsp_addr_lo,
  input  logic        i_rsp_unsigned,
  output logic [31:0] o_rdata
);

  always_comb begin
    o_be = byte_enables(i_size, i_addr_lo);
    case (i_size)
      BYTE:    o_wdata = {4{i_wdata[7:0]}};
      HALF:    o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
    o_rdata = load_extract(i_rdata, i_rsp_size, i_rsp_addr_lo, i_rsp_unsigned);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for a single-ported word RAM; combinational grant, response one cycle later.
// Load/store wins ties until a fetch has waited MAX_WAIT cycles; misaligned accesses complete without touching memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_misaligned,
  output logic              mem_en,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [WAIT_W-1:0] r_wait_cnt;
  owner_e            r_owner;
  logic [1:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic              r_unsigned;
  logic              r_we;

  logic              w_starved;
  logic              w_if_win;
  logic              w_ls_win;
  logic              w_ls_mis;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_ld_data;
  logic              w_unused;

  assign w_unused  = ^if_addr[1:0];
  assign w_starved = (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign w_if_win  = !reset && if_req && (!ls_req || w_starved);
  assign w_ls_win  = !reset && ls_req && !w_if_win;
  assign w_ls_mis  = (ls_size == 2'd3) ||
                     (ls_size == HALF && ls_addr[0]) ||
                     (ls_size == WORD && ls_addr[1:0] != 2'b00);

  assign if_gnt = w_if_win;
  assign ls_gnt = w_ls_win;

  mem_lane_align u_lane (
    .i_size         (ls_size),
    .i_addr_lo      (ls_addr[1:0]),
    .i_wdata        (ls_wdata),
    .o_be           (w_be),
    .o_wdata        (w_wdata_rep),
    .i_rdata        (mem_rdata),
    .i_rsp_size     (r_size),
    .i_rsp_addr_lo  (r_addr_lo),
    .i_rsp_unsigned (r_unsigned),
    .o_rdata        (w_ld_data)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (w_if_win) begin
      mem_en   = 1'b1;
      mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
    end else if (w_ls_win && !w_ls_mis) begin
      mem_en   = 1'b1;
      mem_addr = {ls_addr[ADDR_W-1:2], 2'b00};
      if (ls_we) begin
        mem_be    = w_be;
        mem_wdata = w_wdata_rep;
      end
    end
  end

  // Wait count only ever reaches MAX_WAIT, where the fetch is forced through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (if_req && !w_if_win) begin
      if (!w_starved) r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= NONE;
      r_size     <= 2'b00;
      r_addr_lo  <= 2'b00;
      r_unsigned <= 1'b0;
      r_we       <= 1'b0;
    end else begin
      if (w_if_win) begin
        r_owner <= FETCH;
      end else if (w_ls_win) begin
        r_owner <= w_ls_mis ? LS_MIS : LS;
      end else begin
        r_owner <= NONE;
      end
      if (w_ls_win) begin
        r_size     <= ls_size;
        r_addr_lo  <= ls_addr[1:0];
        r_unsigned <= ls_unsigned;
        r_we       <= ls_we;
      end
    end
  end

  assign if_rvalid     = (r_owner == FETCH);
  assign if_rdata      = if_rvalid ? mem_rdata : 32'h0;
  assign ls_rvalid     = (r_owner == LS) || (r_owner == LS_MIS);
  assign ls_misaligned = (r_owner == LS_MIS);
  assign ls_rdata      = (r_owner == LS && !r_we) ? w_ld_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a byte-array memory reference model.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0, ls_unsigned = 1'b0;
  logic [1:0]  ls_size = 2'b00;
  logic [31:0] ls_addr = 32'h0, ls_wdata = 32'h0;
  logic        ls_gnt, ls_rvalid, ls_misaligned;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ram [0:255];
  logic [7:0]  ref_mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int l = 0; l < 4; l++)
        if (mem_be[l]) ram[mem_addr[9:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
      mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  mem_port_arbiter #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_misaligned(ls_misaligned), .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic mis_model(input int a, input int sz);
    if (sz == 3) return 1'b1;
    return (a % (1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] load_model(input int a, input int sz, input logic uns);
    int n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[a+k]) << (8*k));
    if (!uns && n < 4 && ref_mem[a+n-1][7]) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] be_model(input int a, input int sz);
    logic [3:0] b;
    b = 4'b0000;
    for (int k = 0; k < (1 << sz); k++) b[(a % 4) + k] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] wdata_model(input logic [31:0] wd, input int sz);
    logic [31:0] r;
    int n;
    n = 1 << sz;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % n) +: 8];
    return r;
  endfunction

  task automatic store_model(input int a, input int sz, input logic [31:0] wd);
    for (int k = 0; k < (1 << sz); k++) ref_mem[a+k] = wd[8*k +: 8];
  endtask

  task automatic do_ls(input logic we, input int sz, input logic uns, input int a, input logic [31:0] wd,
                       output logic ok, output logic men, output logic [3:0] be, output logic [31:0] ma,
                       output logic [31:0] mwd, output logic rv, output logic mis, output logic [31:0] rd);
    @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_size = 2'(sz); ls_unsigned = uns;
    ls_addr = 32'(a); ls_wdata = wd;
    ok = 1'b0; men = 1'b0; be = 4'h0; ma = 32'h0; mwd = 32'h0; rv = 1'b0; mis = 1'b0; rd = 32'h0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (ls_gnt) begin
        ok = 1'b1; men = mem_en; be = mem_be; ma = mem_addr; mwd = mem_wdata;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      rv = ls_rvalid; mis = ls_misaligned; rd = ls_rdata;
    end
    ls_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h100; ls_req = 1'b0;
    @(negedge clk); #1;
    vectors++; if (if_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt); end
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    vectors++; if ({if_rvalid, ls_rvalid, ls_misaligned} !== 3'b000) begin
      miscompares++; $display("FAIL rst_rvalid: got %b want 000", {if_rvalid, ls_rvalid, ls_misaligned}); end
    vectors++; if ({if_rdata, ls_rdata, mem_addr, mem_wdata, mem_be} !== '0) begin
      miscompares++; $display("FAIL rst_data: if_rdata %h ls_rdata %h mem_addr %h want 0", if_rdata, ls_rdata, mem_addr); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (if_gnt !== 1'b1 || mem_en !== 1'b1) begin
      miscompares++; $display("FAIL post_rst_grant: gnt %b mem_en %b want 1 1", if_gnt, mem_en); end
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL post_rst_addr: got %h want 100", mem_addr); end
    @(posedge clk); #1;
    if_req = 1'b0;
    vectors++; if (if_rvalid !== 1'b1 || if_rdata !== load_model(32'h100, 2, 1'b1)) begin
      miscompares++; $display("FAIL post_rst_fetch: rvalid %b data %h want 1 %h", if_rvalid, if_rdata, load_model(32'h100, 2, 1'b1)); end
  endtask

  task automatic test_byte();
    logic ok, men, rv, mis;
    logic [3:0] be;
    logic [31:0] ma, mwd, rd;
    do_ls(1'b1, 0, 1'b0, 32'h203, 32'h1234_56A5, ok, men, be, ma, mwd, rv, mis, rd);
    store_model(32'h203, 0, 32'h1234_56A5);
    vectors++; if (!ok || men !== 1'b1 || be !== 4'b1000) begin
      miscompares++; $display("FAIL sb_issue: ok %b en %b be %b want 1 1 1000", ok, men, be); end
    vectors++; if (mwd !== 32'hA5A5_A5A5 || ma !== 32'h200) begin
      miscompares++; $display("FAIL sb_data: wdata %h addr %h want a5a5a5a5 200", mwd, ma); end
    vectors++; if (rv !== 1'b1 || mis !== 1'b0 || rd !== 32'h0) begin
      miscompares++; $display("FAIL sb_ack: rv %b mis %b rd %h want 1 0 0", rv, mis, rd); end
    do_ls(1'b0, 0, 1'b0, 32'h203, 32'h0, ok, men, be, ma, mwd, rv, mis, rd);
    vectors++; if (!ok || be !== 4'b0000 || rd !== load_model(32'h203, 0, 1'b0)) begin
      miscompares++; $display("FAIL lb_signed: be %b rd %h want 0000 %h", be, rd, load_model(32'h203, 0, 1'b0)); end
    do_ls(1'b0, 0, 1'b1, 32'h203, 32'h0, ok, men, be, ma, mwd, rv, mis, rd);
    vectors++; if (!ok || rd !== load_model(32'h203, 0, 1'b1)) begin
      miscompares++; $display("FAIL lb_unsigned: rd %h want %h", rd, load_model(32'h203, 0, 1'b1)); end
  endtask

  task automatic test_half_misaligned();
    logic ok, men, rv, mis;
    logic [3:0] be;
    logic [31:0] ma, mwd, rd;
    do_ls(1'b1, 1, 1'b0, 32'h12, 32'hDEAD_8001, ok, men, be, ma, mwd, rv, mis, rd);
    store_model(32'h12, 1, 32'hDEAD_8001);
    vectors++; if (!ok || be !== 4'b1100 || mwd !== 32'h8001_8001 || ma !== 32'h10) begin
      miscompares++; $display("FAIL sh_issue: be %b wdata %h addr %h want 1100 80018001 10", be, mwd, ma); end
    do_ls(1'b0, 1, 1'b0, 32'h12, 32'h0, ok, men, be, ma, mwd, rv, mis, rd);
    vectors++; if (!ok || rd !== load_model(32'h12, 1, 1'b0)) begin
      miscompares++; $display("FAIL lh_signed: rd %h want %h", rd, load_model(32'h12, 1, 1'b0)); end
    do_ls(1'b0, 2, 1'b0, 32'h12, 32'h0, ok, men, be, ma, mwd, rv, mis, rd);
    vectors++; if (!ok || men !== 1'b0 || rv !== 1'b1 || mis !== 1'b1 || rd !== 32'h0) begin
      miscompares++; $display("FAIL lw_misaligned: en %b rv %b mis %b rd %h want 0 1 1 0", men, rv, mis, rd); end
  endtask

  task automatic test_random_ls();
    logic ok, men, rv, mis, we, uns, exp_mis;
    logic [3:0] be;
    logic [31:0] ma, mwd, rd, wd, exp_rd;
    int a, sz;
    for (int it = 0; it < 150; it++) begin
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 3); a = $urandom_range(0, 1019); wd = $urandom;
      if (sz < 3 && $urandom_range(0, 3) != 0) a = a - (a % (1 << sz));
      exp_mis = mis_model(a, sz);
      exp_rd = (we || exp_mis) ? 32'h0 : load_model(a, sz, uns);
      do_ls(we, sz, uns, a, wd, ok, men, be, ma, mwd, rv, mis, rd);
      if (we && !exp_mis) store_model(a, sz, wd);
      vectors++; if (!ok || men !== !exp_mis || rv !== 1'b1 || mis !== exp_mis) begin
        miscompares++; $display("FAIL rnd_ctl a=%h sz=%0d we=%b: ok %b en %b rv %b mis %b want en %b mis %b",
                                a, sz, we, ok, men, rv, mis, !exp_mis, exp_mis); end
      vectors++; if (rd !== exp_rd) begin
        miscompares++; $display("FAIL rnd_rdata a=%h sz=%0d uns=%b: got %h want %h", a, sz, uns, rd, exp_rd); end
      if (!exp_mis) begin
        vectors++; if (ma !== (32'(a) & ~32'h3) || be !== (we ? be_model(a, sz) : 4'b0000) ||
                       (we && mwd !== wdata_model(wd, sz))) begin
          miscompares++; $display("FAIL rnd_issue a=%h sz=%0d we=%b: addr %h be %b wdata %h", a, sz, we, ma, be, mwd); end
      end
    end
  endtask

  task automatic test_starvation();
    int fa, la;
    logic exp_if;
    fa = 4 * $urandom_range(0, 255); la = 4 * $urandom_range(0, 255);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'(fa);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_unsigned = 1'b0; ls_addr = 32'(la);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_if = (c % (MAX_WAIT + 1)) == MAX_WAIT;
      vectors++; if (if_gnt !== exp_if || ls_gnt !== !exp_if) begin
        miscompares++; $display("FAIL starve_gnt c=%0d: if %b ls %b want if %b", c, if_gnt, ls_gnt, exp_if); end
      @(posedge clk); #1;
      vectors++; if (if_rvalid !== exp_if || ls_rvalid !== !exp_if ||
                     (exp_if ? if_rdata !== load_model(fa, 2, 1'b1) : ls_rdata !== load_model(la, 2, 1'b1))) begin
        miscompares++; $display("FAIL starve_rsp c=%0d: if_rv %b ls_rv %b if_rd %h ls_rd %h", c, if_rvalid, ls_rvalid, if_rdata, ls_rdata); end
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int a, sz;
    logic uns, is_if;
    logic [31:0] exp;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      is_if = (c % 2) == 0;
      sz = $urandom_range(0, 2); uns = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 1020); a = a - (a % (is_if ? 4 : (1 << sz)));
      if_req = is_if; if_addr = 32'(a);
      ls_req = !is_if; ls_we = 1'b0; ls_size = 2'(sz); ls_unsigned = uns; ls_addr = 32'(a);
      exp = is_if ? load_model(a, 2, 1'b1) : load_model(a, sz, uns);
      #1;
      vectors++; if (if_gnt !== is_if || ls_gnt !== !is_if) begin
        miscompares++; $display("FAIL b2b_gnt c=%0d: if %b ls %b", c, if_gnt, ls_gnt); end
      @(posedge clk); #1;
      vectors++; if (if_rvalid !== is_if || ls_rvalid !== !is_if || ls_misaligned !== 1'b0 ||
                     (is_if ? if_rdata !== exp : ls_rdata !== exp)) begin
        miscompares++; $display("FAIL b2b_rsp c=%0d: if_rv %b ls_rv %b if_rd %h ls_rd %h want %h", c, if_rvalid, ls_rvalid, if_rdata, ls_rdata, exp); end
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic ok, men, rv, mis;
    logic [3:0] be;
    logic [31:0] ma, mwd, rd;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_unsigned = 1'b0; ls_addr = 32'h40;
    #1;
    vectors++; if (ls_gnt !== 1'b1) begin miscompares++; $display("FAIL mid_rst_gnt: got %b want 1", ls_gnt); end
    @(posedge clk); #1;
    reset = 1'b1; ls_req = 1'b0;
    #1;
    vectors++; if (ls_rvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rvalid: got %b want 0", ls_rvalid); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL post_rst_idle: ls_rv %b if_rv %b want 0 0", ls_rvalid, if_rvalid); end
    do_ls(1'b0, 1, 1'b1, 32'h86, 32'h0, ok, men, be, ma, mwd, rv, mis, rd);
    vectors++; if (!ok || rv !== 1'b1 || rd !== load_model(32'h86, 1, 1'b1)) begin
      miscompares++; $display("FAIL post_rst_load: ok %b rv %b rd %h want 1 1 %h", ok, rv, rd, load_model(32'h86, 1, 1'b1)); end
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      ram[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    test_reset();
    test_byte();
    test_half_misaligned();
    test_random_ls();
    test_starvation();
    test_back_to_back();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
    $fatal(1);
  end

endmodule
